// File: rtl/ufm_hex_dump.sv
// Byte-to-ASCII hex-dump formatter: turns (address, byte) pairs from the UFM reader
// into "AAAA: HH HH ... HH\r\n" lines, one character per UART handshake.
module ufm_hex_dump #(
  parameter int BYTES_PER_LINE = 16,
  parameter bit ADDR_PREFIX    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic [14:0] in_addr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  col
);

  typedef enum logic [2:0] {IDLE, PFX, HI, LO, SEP, CR, LF} state_t;

  localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

  state_t      state, state_d;
  logic [2:0]  sub, sub_d;
  logic [7:0]  col_d;
  logic [7:0]  out_data_d;
  logic        out_valid_d;
  logic        in_ready_d;
  logic [7:0]  byte_p0;
  logic [15:0] addr_p0;
  logic        take;
  logic        xfer;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] pfx_char(input logic [15:0] a, input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = hex_char(a[15:12]);
      3'd1:    c = hex_char(a[11:8]);
      3'd2:    c = hex_char(a[7:4]);
      3'd3:    c = hex_char(a[3:0]);
      3'd4:    c = 8'h3A;
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  assign take = (state == IDLE) && in_ready && in_valid;
  assign xfer = out_valid && out_ready;

  // Next-character logic: out_data always holds the character of the current state,
  // so each handshake loads the following one and emission runs back-to-back.
  always_comb begin
    state_d     = state;
    sub_d       = sub;
    col_d       = col;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    in_ready_d  = in_ready;
    case (state)
      IDLE: begin
        in_ready_d = 1'b1;
        if (take) begin
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          if (ADDR_PREFIX && col == 8'd0) begin
            state_d    = PFX;
            sub_d      = 3'd0;
            out_data_d = pfx_char({1'b0, in_addr}, 3'd0);
          end else begin
            state_d    = HI;
            out_data_d = hex_char(in_data[7:4]);
          end
        end
      end
      PFX: if (xfer) begin
        if (sub == 3'd5) begin
          state_d    = HI;
          sub_d      = 3'd0;
          out_data_d = hex_char(byte_p0[7:4]);
        end else begin
          sub_d      = sub + 3'd1;
          out_data_d = pfx_char(addr_p0, sub + 3'd1);
        end
      end
      HI: if (xfer) begin
        state_d    = LO;
        out_data_d = hex_char(byte_p0[3:0]);
      end
      LO: if (xfer) begin
        if (col == LAST_COL) begin
          state_d    = CR;
          out_data_d = 8'h0D;
        end else begin
          state_d    = SEP;
          out_data_d = 8'h20;
        end
      end
      SEP: if (xfer) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        col_d       = col + 8'd1;
      end
      CR: if (xfer) begin
        state_d    = LF;
        out_data_d = 8'h0A;
      end
      LF: if (xfer) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        col_d       = 8'd0;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sub       <= 3'd0;
      col       <= 8'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_d;
      sub       <= sub_d;
      col       <= col_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

  // Capture stage: byte and address frozen for the whole emission of this byte.
  always_ff @(posedge clk) begin
    if (take) begin
      byte_p0 <= in_data;
      addr_p0 <= {1'b0, in_addr};
    end
  end

endmodule

// File: tb/tb_ufm_hex_dump.sv
// Bench for ufm_hex_dump: three configurations share one stimulus and are each
// checked against a line-formatting reference model.
module tb_ufm_hex_dump;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic [14:0] in_addr = 15'h0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready  [ND];
  logic [7:0]  out_data  [ND];
  logic        out_valid [ND];
  logic [7:0]  col       [ND];

  always #5 clk = ~clk;

  ufm_hex_dump #(.BYTES_PER_LINE(16), .ADDR_PREFIX(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_addr(in_addr), .in_valid(in_valid),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .col(col[0]));

  ufm_hex_dump #(.BYTES_PER_LINE(2), .ADDR_PREFIX(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_addr(in_addr), .in_valid(in_valid),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .col(col[1]));

  ufm_hex_dump #(.BYTES_PER_LINE(1), .ADDR_PREFIX(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_addr(in_addr), .in_valid(in_valid),
    .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready), .col(col[2]));

  int         bpl_m [ND] = '{16, 2, 1};
  bit         pfx_m [ND] = '{1'b1, 1'b0, 1'b1};

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exq [ND][$];
  logic [7:0] rx  [ND][$];
  int         colm [ND] = '{0, 0, 0};
  int         ncap [ND] = '{0, 0, 0};
  bit         rst_prev [ND] = '{0, 0, 0};
  bit         stall_prev [ND] = '{0, 0, 0};
  logic [7:0] od_prev [ND];
  bit         armed = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string s;
    s = "0123456789ABCDEF";
    return s[n];
  endfunction

  // Reference: the characters one accepted byte should produce, given the line position.
  task automatic model_byte(int d, logic [7:0] b, logic [14:0] a);
    logic [15:0] fa;
    fa = {1'b0, a};
    if (pfx_m[d] && colm[d] == 0) begin
      for (int k = 3; k >= 0; k--) exq[d].push_back(hexc(fa[k*4 +: 4]));
      exq[d].push_back(8'h3A);
      exq[d].push_back(8'h20);
    end
    exq[d].push_back(hexc(b[7:4]));
    exq[d].push_back(hexc(b[3:0]));
    if (colm[d] == bpl_m[d] - 1) begin
      exq[d].push_back(8'h0D);
      exq[d].push_back(8'h0A);
      colm[d] = 0;
    end else begin
      exq[d].push_back(8'h20);
      colm[d]++;
    end
  endtask

  // Looks at the values that the coming rising edge will act on.
  task automatic mon(int d);
    if (rst_prev[d]) begin
      check("reset_in_ready", in_ready[d], 0);
      check("reset_out_valid", out_valid[d], 0);
      check("reset_col", col[d], 0);
      check("reset_out_data", out_data[d], 0);
    end else if (armed) begin
      check("in_ready_when_idle", in_ready[d], exq[d].size() == 0);
      check("out_valid_when_busy", out_valid[d], exq[d].size() != 0);
      if (stall_prev[d]) check("hold_under_stall", {out_valid[d], out_data[d]}, {1'b1, od_prev[d]});
    end
    stall_prev[d] = 1'b0;
    if (rst) begin
      exq[d].delete();
      colm[d] = 0;
      rst_prev[d] = 1'b1;
      return;
    end
    rst_prev[d] = 1'b0;
    if (!armed) return;
    if (out_valid[d] && out_ready) begin
      if (exq[d].size() == 0) check("spurious_char", out_valid[d], 0);
      else check("char", out_data[d], exq[d].pop_front());
      rx[d].push_back(out_data[d]);
    end
    if (in_valid && in_ready[d]) begin
      check("col_at_capture", col[d], colm[d]);
      model_byte(d, in_data, in_addr);
      ncap[d]++;
    end
    stall_prev[d] = out_valid[d] && !out_ready;
    od_prev[d] = out_data[d];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) mon(d);
    if (rst) armed = 1'b1;
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check("rst_ready", in_ready[d], 0);
      check("rst_valid", out_valid[d], 0);
      check("rst_col", col[d], 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", in_ready[0], 1);
  endtask

  task automatic send(int d, logic [7:0] b, logic [14:0] a);
    int n;
    n = 0;
    while (!in_ready[d] && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("send_wait_bound", n < 2000, 1);
    in_data = b;
    in_addr = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e1 [9];
    logic [7:0] e2 [7];
    string      pf [4];
    string      s5;
    int         c0, cyc;
    bit         ir_prev;

    e1 = '{8'h37, 8'h46, 8'h41, 8'h30, 8'h3A, 8'h20, 8'h41, 8'h35, 8'h20};
    e2 = '{8'h30, 8'h30, 8'h20, 8'h46, 8'h46, 8'h0D, 8'h0A};
    pf = '{"7FA0", "7FB0", "7FC0", "7FD0"};

    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Prefixed first byte, consecutive characters.
    out_ready = 1'b1;
    send(0, 8'hA5, 15'h7FA0);
    for (int i = 0; i < 9; i++) begin
      check("pfx_seq", {out_valid[0], out_data[0]}, {1'b1, e1[i]});
      @(posedge clk);
      #1;
    end
    check("pfx_done_valid", out_valid[0], 0);
    check("pfx_done_col", col[0], 1);

    // Line wrap on the two-byte, unprefixed instance.
    do_reset();
    rx[1].delete();
    send(1, 8'h00, 15'h0010);
    send(1, 8'hFF, 15'h0011);
    repeat (12) @(posedge clk);
    #1;
    check("wrap_len", rx[1].size(), 7);
    if (rx[1].size() >= 7)
      for (int i = 0; i < 7; i++) check("wrap_char", rx[1][i], e2[i]);
    check("wrap_col", col[1], 0);
    send(1, 8'h3C, 15'h0012);
    repeat (6) @(posedge clk);
    #1;
    check("wrap_next_len", rx[1].size(), 10);
    if (rx[1].size() >= 8) check("wrap_next_first", rx[1][7], 8'h33);

    // Upstream always valid with changing data: in_ready pulses one cycle per capture.
    do_reset();
    out_ready = 1'b1;
    ir_prev = 1'b0;
    c0 = ncap[0];
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      in_addr = 15'($urandom);
      @(posedge clk);
      #1;
      check("ready_single_cycle", in_ready[0] & ir_prev, 0);
      ir_prev = in_ready[0];
    end
    in_valid = 1'b0;
    check("busy_captured_some", ncap[0] - c0 > 10, 1);

    // Random backpressure and random upstream activity.
    c0 = ncap[0];
    cyc = 0;
    while (ncap[0] - c0 < 1000 && cyc < 40000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      in_addr = 15'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp_bytes_done", ncap[0] - c0 >= 1000, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) check("bp_drained", exq[d].size(), 0);

    // Reset after the third prefix character.
    do_reset();
    out_ready = 1'b1;
    send(0, 8'h5A, 15'h1234);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", out_valid[0], 0);
    check("midrst_col", col[0], 0);
    check("midrst_ready", in_ready[0], 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rx[0].delete();
    send(0, 8'h11, 15'h0ABC);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_len", rx[0].size(), 9);
    s5 = "0ABC: ";
    if (rx[0].size() >= 6)
      for (int i = 0; i < 6; i++) check("midrst_prefix", rx[0][i], s5[i]);

    // Full 64-byte dump with the default geometry.
    do_reset();
    out_ready = 1'b1;
    rx[0].delete();
    for (int i = 0; i < 64; i++) send(0, 8'($urandom), 15'(15'h7FA0 + i));
    repeat (20) @(posedge clk);
    #1;
    check("dump_len", rx[0].size(), 220);
    if (rx[0].size() >= 220)
      for (int l = 0; l < 4; l++) begin
        for (int k = 0; k < 4; k++) check("dump_prefix", rx[0][l*55 + k], pf[l][k]);
        check("dump_colon", rx[0][l*55 + 4], 8'h3A);
        check("dump_cr", rx[0][l*55 + 53], 8'h0D);
        check("dump_lf", rx[0][l*55 + 54], 8'h0A);
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ufm_hex_dump.md
# ufm_hex_dump

Byte-to-ASCII hex-dump formatter between `ufm_reader` and the UART transmitter. It takes one byte and its UFM byte address at a time over a valid/ready handshake. It emits a character stream, one character per handshake, of the form `AAAA: HH HH ... HH\r\n`. Its `in_ready` drives `ufm_reader.read_en`, and its output pair drives `uart.tx_data` / `uart.tx_ack`, with `uart.tx_rdy` as backpressure.

## Interface
- `BYTES_PER_LINE`, default 16: data bytes per output line, range 1–256.
- `ADDR_PREFIX`, default 1: when 1, each line starts with 4 uppercase hex digits of `{1'b0, in_addr}`, then `:`, then space. When 0, there is no prefix.
- `clk` input, 1 bit: single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_data` input, 8 bits: byte from `ufm_reader.ufm_data`.
- `in_addr` input, 15 bits: UFM byte address of `in_data`.
- `in_valid` input, 1 bit: byte present, from `ufm_reader.ufm_valid`.
- `in_ready` output, 1 bit: formatter can accept a byte; drives `ufm_reader.read_en`.
- `out_data` output, 8 bits: ASCII character to UART.
- `out_valid` output, 1 bit: character present; drives `uart.tx_ack`.
- `out_ready` input, 1 bit: UART can accept a character, from `uart.tx_rdy`.
- `col` output, 8 bits: index of the next byte within the current line, 0..BYTES_PER_LINE-1. Debug/LED use.

## Operation
- States: IDLE, PFX, HI, LO, SEP, CR, LF.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - When `in_valid && in_ready`, capture `in_data` and `in_addr` into internal registers.
  - If `col`==0 and `ADDR_PREFIX`=1, go to PFX. Otherwise go to HI.
- PFX: emits 6 characters in order: addr[15:12], [11:8], [7:4], [3:0] as hex digits, then 0x3A (`:`), then 0x20 (space). A 3-bit sub-counter sequences them. Then go to HI.
- HI: emits hex of byte[7:4]. Then go to LO.
- LO: emits hex of byte[3:0].
  - If `col`==BYTES_PER_LINE-1, go to CR.
  - Otherwise go to SEP.
- SEP: emits 0x20. Then `col`←`col`+1 and go to IDLE.
- CR: emits 0x0D. Then go to LF.
- LF: emits 0x0A. Then `col`←0 and go to IDLE.
- Hex encoding is uppercase: nibble 0–9 maps to 0x30–0x39, and A–F maps to 0x41–0x46.
- `in_ready` is registered: it is 1 only in IDLE. Any `in_valid` outside IDLE is ignored and nothing is captured.
- Captured registers do not change while in a non-IDLE state, whatever `in_data` or `in_addr` do.
- `col` update happens on the handshake of the SEP or LF character.
- `col` wraps only through LF; it never exceeds BYTES_PER_LINE-1.
- With BYTES_PER_LINE=1, every byte goes HI, LO, CR, LF, and SEP is never used.

## Timing
- Reset values, held every cycle `rst`=1:
  - state=IDLE, `col`=0, `out_valid`=0, `out_data`=0x00, sub-counter=0.
  - `in_ready`=0 while `rst`=1; it becomes 1 on the first edge after `rst` deasserts.
- Reset mid-line or mid-character: on the next edge, all of the above values apply. A partially sent line is abandoned, with no CR/LF flush.
- Capture edge E (`in_valid && in_ready`): at E, `in_ready`→0, `out_valid`→1, and `out_data` gets the first character.
- Character handshake: a transfer happens on an edge where `out_valid && out_ready`.
  - On that edge, `out_data` loads the next character and `out_valid` stays 1.
  - The result is back-to-back characters, one per cycle maximum.
- While `out_ready`=0, `out_data` and `out_valid` are held stable.
- After the last character of a byte (SEP or LF) is transferred:
  - `out_valid`→0 and `in_ready`→1 on the same edge.
  - Minimum gap between the last character of byte N and the first character of byte N+1 is 1 cycle, because the capture cycle takes IDLE.
- Latency from capture to first character visible is 1 edge, which is the capture edge itself.
- Characters per byte:
  - 3 (HI, LO, SEP) mid-line.
  - 4 (HI, LO, CR, LF) at end of line.
  - Plus 6 when the line prefix is emitted.

## Test plan
- Prefixed first byte (ADDR_PREFIX=1, `col`=0): `in_addr`=0x7FA0, `in_data`=0xA5, `out_ready`=1 continuously → `out_data` sequence 0x37 0x46 0x41 0x30 0x3A 0x20 0x41 0x35 0x20 on 9 consecutive cycles; `col`=1 afterwards.
- Line wrap (BYTES_PER_LINE=2, ADDR_PREFIX=0): bytes 0x00 then 0xFF → 0x30 0x30 0x20, then 0x46 0x46 0x0D 0x0A; `col`=0 afterwards; the next byte emits no prefix.
- Backpressure: `out_ready` toggled 0/1 randomly for 1000 bytes → the received stream matches the golden model exactly; `out_data` never changes while `out_valid`=1 and `out_ready`=0.
- Busy input ignored: `in_valid` held high with changing `in_data` during emission → only bytes captured while `in_ready`=1 appear in the output, with `in_ready` high for exactly 1 cycle per capture when upstream is always valid.
- Reset mid-prefix: assert `rst` after the third prefix character → the next cycle has `out_valid`=0, `col`=0, and `in_ready`=0; after deassertion, the next byte starts with a full prefix.
- Full 64-byte dump at 0x7FA0 (defaults) → 4 lines, each of 6+16×3+1 = 55 characters, each ending in 0x0D 0x0A, with prefixes 7FA0, 7FB0, 7FC0, 7FD0.
